// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory responder for the MEM stage, byte/half/word access.
// Latency: LATENCY cycles from the acceptance edge to the one-cycle resp_valid strobe (misaligned: 1 when DMEM_MISALIGN_CHECK_EN).
// Backpressure: req_ready only in IDLE; stall freezes the pipeline while a request waits or is in flight.
//
// Ports:
//   clock, reset (async, active-high)
//   req_valid/req_we/req_addr/req_wdata/req_size/req_unsigned : request from MEM stage
//   req_ready   : request accepted this cycle (IDLE only)
//   resp_valid  : one-cycle response strobe, resp_rdata : extended load data (0 for stores/errors)
//   stall       : (IDLE and req_valid) or BUSY
//   misalign_err: valid with resp_valid
// Optional macro: DMEM_MISALIGN_CHECK_EN -- misaligned half/word accesses are flagged and skip memory
// instead of being force-aligned.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        stall,
  output logic        misalign_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;

  // Latched request (only the address bits that select a word and lane are kept)
  logic            r_we;
  logic [AW+1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [1:0]      r_size;
  logic            r_uns;
  logic            r_mis;

  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_accept;
  logic [AW+1:0]   w_in_addr;
  logic            w_in_mis;
  logic            w_enter_resp;
  logic            w_cur_we;
  logic [AW+1:0]   w_cur_addr;
  logic [31:0]     w_cur_wdata;
  logic [1:0]      w_cur_size;
  logic            w_cur_mis;
  logic [3:0]      w_wr_be;
  logic [31:0]     w_wr_dat;
  logic            w_mem_we;
  logic [31:0]     w_rd_word;
  logic [31:0]     w_rd_shift;
  logic            w_unused;

  // Upper address bits beyond the memory depth wrap around.
  assign w_unused = ^req_addr[31:AW+2];

  assign w_accept = (r_state == IDLE) && req_valid;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_in_addr = req_addr[AW+1:0];
  always_comb begin
    w_in_mis = 1'b0;
    case (req_size)
      2'b00:   w_in_mis = 1'b0;
      2'b01:   w_in_mis = req_addr[0];
      default: w_in_mis = (req_addr[1:0] != 2'b00);
    endcase
  end
`else
  // Misaligned addresses are silently rounded down to the access size.
  always_comb begin
    w_in_addr = req_addr[AW+1:0];
    case (req_size)
      2'b00:   w_in_addr = req_addr[AW+1:0];
      2'b01:   w_in_addr[0] = 1'b0;
      default: w_in_addr[1:0] = 2'b00;
    endcase
  end
  assign w_in_mis = 1'b0;
`endif

  // When LATENCY is 1 the store commits on the acceptance edge itself, so the
  // commit path must look at the live request instead of the latched copy.
  always_comb begin
    if (r_state == IDLE) begin
      w_cur_we    = req_we;
      w_cur_addr  = w_in_addr;
      w_cur_wdata = req_wdata;
      w_cur_size  = req_size;
      w_cur_mis   = w_in_mis;
    end else begin
      w_cur_we    = r_we;
      w_cur_addr  = r_addr;
      w_cur_wdata = r_wdata;
      w_cur_size  = r_size;
      w_cur_mis   = r_mis;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if ((LATENCY == 1) || w_in_mis) begin
            w_state_nxt  = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt  = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_mis   <= 1'b0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= w_in_addr;
      r_wdata <= req_wdata;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_mis   <= w_in_mis;
    end
  end

  // Store lane enables and lane-replicated data
  always_comb begin
    w_wr_be  = 4'b1111;
    w_wr_dat = w_cur_wdata;
    case (w_cur_size)
      2'b00: begin
        w_wr_be  = 4'b0001 << w_cur_addr[1:0];
        w_wr_dat = {4{w_cur_wdata[7:0]}};
      end
      2'b01: begin
        w_wr_be  = w_cur_addr[1] ? 4'b1100 : 4'b0011;
        w_wr_dat = {2{w_cur_wdata[15:0]}};
      end
      default: begin
        w_wr_be  = 4'b1111;
        w_wr_dat = w_cur_wdata;
      end
    endcase
  end

  // Gating with reset keeps a store from landing on an edge that coincides with reset.
  assign w_mem_we = w_enter_resp && w_cur_we && !w_cur_mis && !reset;

  // Memory contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr_be[i]) begin
          r_mem[w_cur_addr[AW+1:2]][8*i +: 8] <= w_wr_dat[8*i +: 8];
        end
      end
    end
  end

  // Reads are combinational in RESP, so a store committed earlier is always visible.
  assign w_rd_word  = r_mem[r_addr[AW+1:2]];
  assign w_rd_shift = w_rd_word >> {r_addr[1:0], 3'b000};

  always_comb begin
    resp_rdata = 32'd0;
    if ((r_state == RESP) && !r_we && !r_mis) begin
      case (r_size)
        2'b00:   resp_rdata = r_uns ? {24'd0, w_rd_shift[7:0]}
                                    : {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
        2'b01:   resp_rdata = r_uns ? {16'd0, w_rd_shift[15:0]}
                                    : {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
        default: resp_rdata = w_rd_word;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign stall      = ((r_state == IDLE) && req_valid) || (r_state == BUSY);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misalign_err = (r_state == RESP) && r_mis;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_ready, resp_valid, stall, misalign_err;
  logic [31:0] resp_rdata;

  logic        q_valid, q_we, q_unsigned;
  logic [31:0] q_addr, q_wdata;
  logic [1:0]  q_size;
  logic        q_ready, q_resp_valid, q_stall, q_misalign_err;
  logic [31:0] q_resp_rdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       tag;
  } exp_t;
  exp_t sb[$];

  always #5 clock = ~clock;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .stall(stall), .misalign_err(misalign_err)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clock(clock), .reset(reset),
    .req_valid(q_valid), .req_we(q_we), .req_addr(q_addr),
    .req_wdata(q_wdata), .req_size(q_size), .req_unsigned(q_unsigned),
    .req_ready(q_ready), .resp_valid(q_resp_valid), .resp_rdata(q_resp_rdata),
    .stall(q_stall), .misalign_err(q_misalign_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Issue one request on the LATENCY=2 instance; entered and left at posedge+1 in IDLE.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns,
                        input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    exp_t e;
    exp_t got;
    int   n;
    int   st;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_err ? 1 : 2;
    e.tag   = tag;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    sb.push_back(e);
    #1;
    check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    st = stall ? 1 : 0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    // Scramble the bus: latched request must be used from here on.
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555; req_we = ~we; req_size = 2'b00;
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      if (stall) st++;
      @(posedge clock); #1;
      n++;
    end
    check({tag, ".resp_seen"}, {31'd0, resp_valid}, 32'd1);
    if (resp_valid === 1'b1 && sb.size() > 0) begin
      got = sb.pop_front();
      check({got.tag, ".rdata"}, resp_rdata, got.rdata);
      check({got.tag, ".err"}, {31'd0, misalign_err}, {31'd0, got.err});
      check({got.tag, ".latency"}, n + 1, got.lat);
      check({got.tag, ".stall_cycles"}, st, got.lat);
      check({got.tag, ".stall_in_resp"}, {31'd0, stall}, 32'd0);
      check({got.tag, ".ready_in_resp"}, {31'd0, req_ready}, 32'd0);
    end
    @(posedge clock); #1;
    check({tag, ".resp_one_cycle"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_unsigned = 0;
    q_valid = 0; q_we = 0; q_addr = 0; q_wdata = 0; q_size = 0; q_unsigned = 0;
    @(posedge clock); @(posedge clock); #1;

    // Reset state
    check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst.rdata", resp_rdata, 32'd0);
    check("rst.err", {31'd0, misalign_err}, 32'd0);
    check("rst.ready", {31'd0, req_ready}, 32'd1);
    check("rst.stall_idle", {31'd0, stall}, 32'd0);
    req_valid = 1'b1; #1;
    check("rst.stall_req", {31'd0, stall}, 32'd1);
    req_valid = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;

    // Word store / load
    do_req(1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0, "st_word");
    do_req(0, 32'h10, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0, "ld_word");

    // Byte store into a cleared word, signed/unsigned byte loads
    do_req(1, 32'h10, 32'h0, 2'b10, 0, 32'h0, 0, "clr_word");
    do_req(1, 32'h13, 32'h80, 2'b00, 0, 32'h0, 0, "st_byte");
    do_req(0, 32'h13, 32'h0, 2'b00, 0, 32'hFFFFFF80, 0, "ld_byte_s");
    do_req(0, 32'h13, 32'h0, 2'b00, 1, 32'h00000080, 0, "ld_byte_u");
    do_req(0, 32'h10, 32'h0, 2'b10, 0, 32'h80000000, 0, "ld_word_b");

    // Half accesses; word @0x10 becomes 0x80010000
    do_req(1, 32'h12, 32'h8001, 2'b01, 0, 32'h0, 0, "st_half");
    do_req(0, 32'h12, 32'h0, 2'b01, 0, 32'hFFFF8001, 0, "ld_half_s");
    do_req(0, 32'h12, 32'h0, 2'b01, 1, 32'h00008001, 0, "ld_half_u");
    do_req(0, 32'h10, 32'h0, 2'b11, 1, 32'h80010000, 0, "ld_size3");

    // Misaligned half store @0x11: flagged, or force-aligned into lanes 0/1
    do_req(1, 32'h11, 32'hABCD, 2'b01, 0, 32'h0, MIS_EN, "st_half_mis");
    do_req(0, 32'h10, 32'h0, 2'b10, 0, MIS_EN ? 32'h80010000 : 32'h8001ABCD, 0, "ld_after_mis");
    do_req(0, 32'h12, 32'h0, 2'b10, 0, MIS_EN ? 32'h0 : 32'h8001ABCD, MIS_EN, "ld_word_mis");

    // Address wrap-around
    do_req(1, 32'h00001004, 32'h5A5AA5A5, 2'b10, 0, 32'h0, 0, "st_wrap");
    do_req(0, 32'h00000004, 32'h0, 2'b10, 0, 32'h5A5AA5A5, 0, "ld_wrap");

    // Reset during BUSY of a store drops it
    do_req(1, 32'h20, 32'hCAFEF00D, 2'b10, 0, 32'h0, 0, "st_prior");
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_size = 2'b10;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("rst_mid.busy_ready", {31'd0, req_ready}, 32'd0);
    check("rst_mid.busy_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1; #1;
    check("rst_mid.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mid.ready", {31'd0, req_ready}, 32'd1);
    check("rst_mid.stall", {31'd0, stall}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    do_req(0, 32'h20, 32'h0, 2'b10, 0, 32'hCAFEF00D, 0, "ld_after_rst");

    // LATENCY=1 instance, req_valid held high across back-to-back accesses
    q_valid = 1'b1; q_we = 1'b1; q_addr = 32'h8; q_wdata = 32'h11223344; q_size = 2'b10; q_unsigned = 1'b0;
    #1;
    check("l1.ready0", {31'd0, q_ready}, 32'd1);
    @(posedge clock); #1;
    check("l1.resp0", {31'd0, q_resp_valid}, 32'd1);
    check("l1.ready_resp0", {31'd0, q_ready}, 32'd0);
    check("l1.stall_resp0", {31'd0, q_stall}, 32'd0);
    check("l1.rdata_store", q_resp_rdata, 32'd0);
    q_we = 1'b0;
    @(posedge clock); #1;
    check("l1.ready1", {31'd0, q_ready}, 32'd1);
    check("l1.idle_resp", {31'd0, q_resp_valid}, 32'd0);
    check("l1.stall1", {31'd0, q_stall}, 32'd1);
    @(posedge clock); #1;
    check("l1.resp1", {31'd0, q_resp_valid}, 32'd1);
    check("l1.ready_resp1", {31'd0, q_ready}, 32'd0);
    check("l1.rdata", q_resp_rdata, 32'h11223344);
    check("l1.err", {31'd0, q_misalign_err}, 32'd0);
    q_valid = 1'b0;
    @(posedge clock); #1;
    check("l1.done", {31'd0, q_resp_valid}, 32'd0);

    check("sb.empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
